// File: rtl/rev_pkg.sv
// Shared types for the reversible accumulate stage: direction, FSM state
// encoding and the layout of one history entry.
package rev_pkg;

  localparam int unsigned P_W = 16;
  localparam int unsigned A_W = 8;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } rev_dir_e;

  typedef enum logic [1:0] {
    FWD  = 2'd0,
    SW_B = 2'd1,
    BWD  = 2'd2,
    SW_F = 2'd3
  } acc_state_e;

  typedef struct packed {
    logic [P_W-1:0] p;
    logic [A_W-1:0] a;
  } hist_entry_t;

endpackage

// File: rtl/rev_lifo.sv
// Register-array stack holding the forward history. Only the pointer is
// reset; entry contents are meaningless once popped or after reset.
module rev_lifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 24,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [CNT_W-1:0] ptr_r;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;
  logic [CNT_W-1:0] ptr_dec_s;

  // Index, status and top-of-stack decode from the occupancy pointer.
  always_comb begin
    ptr_dec_s = ptr_r - CNT_W'(1'b1);
    wr_idx_s  = ptr_r[AW-1:0];
    rd_idx_s  = ptr_dec_s[AW-1:0];
    full      = (ptr_r == CNT_W'(DEPTH));
    empty     = (ptr_r == {CNT_W{1'b0}});
    if (empty) begin
      top = {W{1'b0}};
    end else begin
      top = mem_r[rd_idx_s];
    end
  end

  // Occupancy pointer; push and pop are mutually exclusive upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {CNT_W{1'b0}};
    end else if (push && !full) begin
      ptr_r <= ptr_r + CNT_W'(1'b1);
    end else if (pop && !empty) begin
      ptr_r <= ptr_dec_s;
    end
  end

  // Entry storage, written at the current pointer on push.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_idx_s] <= wdata;
    end
  end

  assign count = ptr_r;

endmodule

// File: rtl/rev_mac_acc.sv
// Reversible accumulate stage: forward adds products and records history,
// backward pops history and subtracts, handing {p, a} back upstream.
module rev_mac_acc #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned P_W   = 16,
  parameter int unsigned A_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dir,
  input  logic                         fin_valid,
  output logic                         fin_ready,
  input  logic [P_W-1:0]               fin_p,
  input  logic [A_W-1:0]               fin_a,
  output logic                         bout_valid,
  input  logic                         bout_ready,
  output logic [P_W-1:0]               bout_p,
  output logic [15:0]                  bout_a_b,
  output logic [ACC_W-1:0]             acc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         mode_bwd
);

  import rev_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned E_W   = P_W + A_W;

  acc_state_e       state_r;
  logic             en_r;
  logic             mode_bwd_r;
  logic [ACC_W-1:0] acc_r;

  logic             dir_bwd_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             fin_ready_s;
  logic             bout_valid_s;
  logic [E_W-1:0]   top_s;
  logic [P_W-1:0]   top_p_s;
  logic [A_W-1:0]   top_a_s;
  logic [CNT_W-1:0] count_s;

  rev_lifo #(
    .DEPTH (DEPTH),
    .W     (E_W),
    .CNT_W (CNT_W)
  ) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({fin_p, fin_a}),
    .top   (top_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Handshake qualification; readiness is gated by the live dir input so a
  // direction change never completes a transfer in the cycle it happens.
  always_comb begin
    dir_bwd_s    = (rev_dir_e'(dir) == DIR_BWD);
    fin_ready_s  = en_r && (state_r == FWD) && !dir_bwd_s && !full_s;
    bout_valid_s = (state_r == BWD) && dir_bwd_s && !empty_s;
    push_s       = fin_valid && fin_ready_s;
    pop_s        = bout_valid_s && bout_ready;
    top_p_s      = top_s[E_W-1:A_W];
    top_a_s      = top_s[A_W-1:0];
  end

  // Direction FSM with a one-cycle bubble on every switch; en_r keeps
  // fin_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FWD;
      mode_bwd_r <= 1'b0;
      en_r       <= 1'b0;
    end else begin
      en_r <= 1'b1;
      case (state_r)
        FWD: begin
          state_r    <= dir_bwd_s ? SW_B : FWD;
          mode_bwd_r <= 1'b0;
        end
        SW_B: begin
          state_r    <= dir_bwd_s ? BWD : FWD;
          mode_bwd_r <= dir_bwd_s;
        end
        BWD: begin
          state_r    <= dir_bwd_s ? BWD : SW_F;
          mode_bwd_r <= dir_bwd_s;
        end
        SW_F: begin
          state_r    <= dir_bwd_s ? BWD : FWD;
          mode_bwd_r <= dir_bwd_s;
        end
        default: begin
          state_r    <= FWD;
          mode_bwd_r <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator; wrap is intentional since a later pop undoes it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (push_s) begin
      acc_r <= acc_r + ACC_W'(fin_p);
    end else if (pop_s) begin
      acc_r <= acc_r - ACC_W'(top_p_s);
    end
  end

  // Backward payload is forced to zero whenever it is not being offered.
  always_comb begin
    if (bout_valid_s) begin
      bout_p   = top_p_s;
      bout_a_b = 16'(top_a_s);
    end else begin
      bout_p   = {P_W{1'b0}};
      bout_a_b = 16'h0000;
    end
  end

  assign fin_ready  = fin_ready_s;
  assign bout_valid = bout_valid_s;
  assign acc        = acc_r;
  assign count      = count_s;
  assign mode_bwd   = mode_bwd_r;

endmodule

// File: tb/tb_rev_mac_acc.sv
// Scoreboard bench for rev_mac_acc: a default instance plus a 16-bit
// accumulator instance for the wrap case, selected by sel.
module tb_rev_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dir;
  logic        fin_valid;
  logic        bout_ready;
  logic        sel;
  logic [15:0] fin_p;
  logic [7:0]  fin_a;

  logic        fr1, bv1, mb1, fr2, bv2, mb2;
  logic [15:0] bp1, bab1, bp2, bab2;
  logic [23:0] acc1;
  logic [15:0] acc2;
  logic [3:0]  cnt1, cnt2;

  logic        v_fr, v_bv, v_mb;
  logic [15:0] v_bp, v_bab;
  logic [23:0] v_acc;
  logic [3:0]  v_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [27:0] exp_q[$];
  logic [31:0] pair_q[$];

  always #5 clk = ~clk;

  rev_mac_acc dut (
    .clk(clk), .rst_n(rst_n), .dir(dir),
    .fin_valid(fin_valid & ~sel), .fin_ready(fr1), .fin_p(fin_p), .fin_a(fin_a),
    .bout_valid(bv1), .bout_ready(bout_ready & ~sel), .bout_p(bp1), .bout_a_b(bab1),
    .acc(acc1), .count(cnt1), .mode_bwd(mb1)
  );

  rev_mac_acc #(.ACC_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .dir(dir),
    .fin_valid(fin_valid & sel), .fin_ready(fr2), .fin_p(fin_p), .fin_a(fin_a),
    .bout_valid(bv2), .bout_ready(bout_ready & sel), .bout_p(bp2), .bout_a_b(bab2),
    .acc(acc2), .count(cnt2), .mode_bwd(mb2)
  );

  assign v_fr  = sel ? fr2 : fr1;
  assign v_bv  = sel ? bv2 : bv1;
  assign v_mb  = sel ? mb2 : mb1;
  assign v_bp  = sel ? bp2 : bp1;
  assign v_bab = sel ? bab2 : bab1;
  assign v_acc = sel ? {8'h00, acc2} : acc1;
  assign v_cnt = sel ? cnt2 : cnt1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p, input logic [7:0] a,
                      input logic [23:0] e_acc, input logic [3:0] e_cnt);
    bit ok;
    ok = 1'b0;
    fin_p = p;
    fin_a = a;
    fin_valid = 1'b1;
    exp_q.push_back({e_acc, e_cnt});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v_fr) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: fin_ready never rose for p=%h", p);
      void'(exp_q.pop_back());
    end else begin
      @(posedge clk);
    end
    #1;
    fin_valid = 1'b0;
  endtask

  task automatic pop(input logic [15:0] e_p, input logic [15:0] e_ab,
                     input logic [23:0] e_acc, input logic [3:0] e_cnt);
    bit ok;
    ok = 1'b0;
    bout_ready = 1'b1;
    pair_q.push_back({e_p, e_ab});
    exp_q.push_back({e_acc, e_cnt});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v_bv) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL pop_timeout: bout_valid never rose, want p=%h", e_p);
      void'(pair_q.pop_back());
      void'(exp_q.pop_back());
    end else begin
      @(posedge clk);
    end
    #1;
    bout_ready = 1'b0;
  endtask

  // Monitor: checks acc/count after every handshake and the offered pair
  // at every backward handshake, against expectations queued by stimulus.
  initial begin : monitor
    logic        hs_prev;
    logic [27:0] e;
    logic [31:0] pr;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_handshake: acc=%h count=%0d", v_acc, v_cnt);
        end else begin
          e = exp_q.pop_front();
          check("acc", 32'(v_acc), 32'(e[27:4]));
          check("count", 32'(v_cnt), 32'(e[3:0]));
        end
      end
      hs_prev = (fin_valid && v_fr) || (v_bv && bout_ready);
      if (v_bv && bout_ready) begin
        if (pair_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: p=%h a_b=%h", v_bp, v_bab);
        end else begin
          pr = pair_q.pop_front();
          check("bout_p", 32'(v_bp), 32'(pr[31:16]));
          check("bout_a_b", 32'(v_bab), 32'(pr[15:0]));
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    dir = 1'b0;
    fin_valid = 1'b0;
    bout_ready = 1'b0;
    sel = 1'b0;
    fin_p = 16'h0000;
    fin_a = 8'h00;

    // Reset state
    #12;
    check("rst_acc", 32'(v_acc), 32'h0);
    check("rst_count", 32'(v_cnt), 32'h0);
    check("rst_fin_ready", 32'(v_fr), 32'h0);
    check("rst_bout_valid", 32'(v_bv), 32'h0);
    check("rst_bout_p", 32'(v_bp), 32'h0);
    check("rst_bout_a_b", 32'(v_bab), 32'h0);
    check("rst_mode_bwd", 32'(v_mb), 32'h0);
    #10;
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(v_fr), 32'h1);

    // Forward pushes
    push(16'h0048, 8'h12, 24'h000048, 4'd1);
    push(16'h0088, 8'h08, 24'h0000D0, 4'd2);
    check("t1_fin_ready", 32'(v_fr), 32'h1);

    // Backward pops with the SW_B bubble
    dir = 1'b1;
    #1;
    check("t2_dirchg_fr", 32'(v_fr), 32'h0);
    check("t2_dirchg_bv", 32'(v_bv), 32'h0);
    tick();
    check("t2_swb_fr", 32'(v_fr), 32'h0);
    check("t2_swb_bv", 32'(v_bv), 32'h0);
    check("t2_swb_mode", 32'(v_mb), 32'h0);
    tick();
    check("t2_bwd_bv", 32'(v_bv), 32'h1);
    check("t2_bwd_mode", 32'(v_mb), 32'h1);
    check("t2_top_p", 32'(v_bp), 32'h0088);
    check("t2_top_ab", 32'(v_bab), 32'h0008);
    pop(16'h0088, 16'h0008, 24'h000048, 4'd1);
    pop(16'h0048, 16'h0012, 24'h000000, 4'd0);
    check("t2_empty_bv", 32'(v_bv), 32'h0);
    check("t2_empty_bp", 32'(v_bp), 32'h0);
    check("t2_empty_acc", 32'(v_acc), 32'h0);
    bout_ready = 1'b1;
    tick();
    tick();
    bout_ready = 1'b0;
    check("t2_empty_hold_acc", 32'(v_acc), 32'h0);
    dir = 1'b0;
    tick();
    check("t2_swf_fr", 32'(v_fr), 32'h0);
    check("t2_swf_mode", 32'(v_mb), 32'h0);
    tick();
    check("t2_back_fwd_fr", 32'(v_fr), 32'h1);

    // Dir glitch with a product already offered
    fin_p = 16'h0100;
    fin_a = 8'h33;
    fin_valid = 1'b1;
    dir = 1'b1;
    exp_q.push_back({24'h000100, 4'd1});
    #1;
    check("t5_glitch_fr0", 32'(v_fr), 32'h0);
    tick();
    dir = 1'b0;
    #1;
    check("t5_glitch_fr1", 32'(v_fr), 32'h0);
    check("t5_glitch_cnt", 32'(v_cnt), 32'h0);
    tick();
    check("t5_glitch_fr2", 32'(v_fr), 32'h1);
    tick();
    fin_valid = 1'b0;
    dir = 1'b1;
    pop(16'h0100, 16'h0033, 24'h000000, 4'd0);
    dir = 1'b0;
    tick();
    tick();

    // Wrap on the 16-bit accumulator instance
    sel = 1'b1;
    #1;
    push(16'hFFFF, 8'h01, 24'h00FFFF, 4'd1);
    push(16'h0002, 8'h02, 24'h000001, 4'd2);
    dir = 1'b1;
    pop(16'h0002, 16'h0002, 24'h00FFFF, 4'd1);
    pop(16'hFFFF, 16'h0001, 24'h000000, 4'd0);
    dir = 1'b0;
    tick();
    tick();
    sel = 1'b0;
    #1;

    // Full, held 9th product, then drain in LIFO order
    for (int i = 0; i < 8; i++) begin
      push(16'hFFFF, 8'(i), 24'((i + 1) * 32'h0000FFFF), 4'(i + 1));
    end
    check("t3_full_fr", 32'(v_fr), 32'h0);
    check("t3_full_acc", 32'(v_acc), 32'h07FFF8);
    fin_p = 16'h1234;
    fin_a = 8'hAA;
    fin_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_fr", 32'(v_fr), 32'h0);
      check("t3_hold_acc", 32'(v_acc), 32'h07FFF8);
    end
    fin_valid = 1'b0;
    dir = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      pop(16'hFFFF, 16'(k), 24'(k * 32'h0000FFFF), 4'(k));
    end
    dir = 1'b0;
    tick();
    tick();

    // Asynchronous reset mid-operation
    push(16'h0011, 8'h01, 24'h000011, 4'd1);
    push(16'h0022, 8'h02, 24'h000033, 4'd2);
    push(16'h0033, 8'h03, 24'h000066, 4'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_acc", 32'(v_acc), 32'h0);
    check("t6_rst_count", 32'(v_cnt), 32'h0);
    check("t6_rst_fr", 32'(v_fr), 32'h0);
    check("t6_rst_bv", 32'(v_bv), 32'h0);
    check("t6_rst_bp", 32'(v_bp), 32'h0);
    check("t6_rst_bab", 32'(v_bab), 32'h0);
    #10;
    rst_n = 1'b1;
    #1;
    check("t6_release_fr", 32'(v_fr), 32'h0);
    tick();
    check("t6_next_fr", 32'(v_fr), 32'h1);
    check("t6_next_cnt", 32'(v_cnt), 32'h0);

    tick();
    tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("pair_q_drained", 32'(pair_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
